// File: rtl/uadd_pkg.sv
// Shared constants and elaboration helpers for the pipelined unsigned adder.
// Pipeline register layout: per stage, {b_hi, a_hi, sum_lo} packed back to back.
package uadd_pkg;

  localparam int unsigned UADD_WIDTH_DEF  = 32;
  localparam int unsigned UADD_STAGES_DEF = 4;

  // Legal when 1 <= stages <= width and the width splits into equal slices.
  function automatic bit uadd_params_ok(input int unsigned width, input int unsigned stages);
    if (width < 1 || stages < 1 || stages > width) begin
      return 1'b0;
    end
    return (width % stages) == 0;
  endfunction

  // Bits held by stage k: completed low sum plus the not-yet-added upper A and B.
  function automatic int unsigned uadd_stage_bits(input int unsigned width,
                                                  input int unsigned stages,
                                                  input int unsigned k);
    if (stages == 0) begin
      return 0;
    end
    return 2 * width - (k + 1) * (width / stages);
  endfunction

  // Bit offset of stage k inside the flat pipeline register.
  function automatic int unsigned uadd_stage_off(input int unsigned width,
                                                 input int unsigned stages,
                                                 input int unsigned k);
    int unsigned off;
    off = 0;
    for (int unsigned j = 0; j < k; j++) begin
      off += uadd_stage_bits(width, stages, j);
    end
    return off;
  endfunction

endpackage

// File: rtl/uadd_slice.sv
// Combinational slice adder: WIDTH-bit operands plus carry-in to sum and carry-out.
module uadd_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  always_comb begin
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
  end

endmodule

// File: rtl/pipelined_unsigned_adder.sv
// Streaming WIDTH-bit unsigned adder, carry chain cut into STAGES registered slices.
// Define UADD_SATURATE_EN to clamp the sum to all-ones on carry-out.
module pipelined_unsigned_adder
  import uadd_pkg::*;
#(
  parameter int unsigned WIDTH  = UADD_WIDTH_DEF,
  parameter int unsigned STAGES = UADD_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int unsigned SLICE     = WIDTH / STAGES;
  localparam int unsigned PIPE_BITS = uadd_stage_off(WIDTH, STAGES, STAGES);
  localparam int unsigned LAST_OFF  = uadd_stage_off(WIDTH, STAGES, STAGES - 1);

  if (!uadd_params_ok(WIDTH, STAGES)) begin : g_param_check
    $fatal(1, "pipelined_unsigned_adder: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
  end

  logic                 advance;
  logic [STAGES-1:0]    valid_d, valid_q;
  logic [STAGES-1:0]    carry_d, carry_q;
  logic [PIPE_BITS-1:0] pipe_d, pipe_q;

  assign out_valid = valid_q[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Off = uadd_stage_off(WIDTH, STAGES, k);
    localparam int unsigned LoW = (k + 1) * SLICE;
    localparam int unsigned HiW = WIDTH - LoW;

    logic [SLICE-1:0] op_a;
    logic [SLICE-1:0] op_b;
    logic             op_cin;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;

    if (k == 0) begin : g_head
      assign op_a   = in_a[SLICE-1:0];
      assign op_b   = in_b[SLICE-1:0];
      assign op_cin = in_cin;
      assign pipe_d[Off +: SLICE] = slice_sum;
      if (HiW > 0) begin : g_skew
        assign pipe_d[Off + LoW +: HiW]       = in_a[SLICE +: HiW];
        assign pipe_d[Off + LoW + HiW +: HiW] = in_b[SLICE +: HiW];
      end
    end else begin : g_body
      // Previous stage region: {b_hi (PHiW), a_hi (PHiW), sum_lo (k*SLICE)}.
      localparam int unsigned POff = uadd_stage_off(WIDTH, STAGES, k - 1);
      localparam int unsigned PLoW = k * SLICE;
      localparam int unsigned PHiW = WIDTH - PLoW;

      assign op_a   = pipe_q[POff + PLoW +: SLICE];
      assign op_b   = pipe_q[POff + PLoW + PHiW +: SLICE];
      assign op_cin = carry_q[k-1];
      assign pipe_d[Off +: LoW] = {slice_sum, pipe_q[POff +: PLoW]};
      if (HiW > 0) begin : g_skew
        assign pipe_d[Off + LoW +: HiW]       = pipe_q[POff + PLoW + SLICE +: HiW];
        assign pipe_d[Off + LoW + HiW +: HiW] = pipe_q[POff + PLoW + PHiW + SLICE +: HiW];
      end
    end

    assign carry_d[k] = slice_cout;

    uadd_slice #(
      .WIDTH (SLICE)
    ) u_slice (
      .a_i    (op_a),
      .b_i    (op_b),
      .cin_i  (op_cin),
      .sum_o  (slice_sum),
      .cout_o (slice_cout)
    );
  end

  always_comb begin
    valid_d    = valid_q;
    valid_d[0] = in_valid && in_ready;
    for (int unsigned k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
    end
  end

  // Whole pipe moves as one; a stalled output freezes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      pipe_q  <= '0;
    end else if (advance) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      pipe_q  <= pipe_d;
    end
  end

  always_comb begin
    out_sum  = '0;
    out_cout = 1'b0;
    if (out_valid) begin
      out_cout = carry_q[STAGES-1];
      out_sum  = pipe_q[LAST_OFF +: WIDTH];
`ifdef UADD_SATURATE_EN
      if (carry_q[STAGES-1]) begin
        out_sum = '1;
      end
`else
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_unsigned_adder.sv
// Scoreboard bench: four adder configurations run in parallel against an arithmetic model.
module tb_pipelined_unsigned_adder;

  localparam int NCFG = 4;

  function automatic int cfg_w(input int i);
    case (i)
      0:       return 32;
      1:       return 8;
      2:       return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_s(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_ops(input int i);
    return (i == 0) ? 200 : 1000;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < NCFG; g++) begin : blk
    localparam int W = cfg_w(g);
    localparam int S = cfg_s(g);

    logic         rst_n, in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
    logic [W-1:0] in_a, in_b, out_sum;

    logic [W:0] exp_q[$];
    int         tp_q[$];
    int         st_q[$];
    int         cyc       = 0;
    int         stall_cnt = 0;
    bit         fresh     = 1'b1;
    bit         saw_block = 1'b0;
    bit         rnd_rdy   = 1'b0;
    bit         done      = 1'b0;

    pipelined_unsigned_adder #(
      .WIDTH  (W),
      .STAGES (S)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
      logic [W:0] r;
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
`ifdef UADD_SATURATE_EN
      if (r[W]) r[W-1:0] = '1;
`endif
      return r;
    endfunction

    function automatic logic [W-1:0] rnd();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
        0:       r = '1;
        1:       r = '0;
        default: ;
      endcase
      return r[W-1:0];
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int t;
      t        = 0;
      in_a     = a;
      in_b     = b;
      in_cin   = c;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        n_cmp++;
        n_fail++;
        $display("FAIL cfg%0d accept_timeout: in_ready=%0b after %0d cycles, want 1", g, in_ready, t);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    endtask

    // Monitor: checks outputs, handshake and latency; records accepted inputs.
    always @(negedge clk) begin
      logic       stall;
      logic [W:0] e;
      int         lat;
      if (!rst_n) begin
        n_cmp++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 || in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL cfg%0d reset_state: valid=%0b sum=%0h cout=%0b rdy=%0b, want 0/0/0/1",
                   g, out_valid, out_sum, out_cout, in_ready);
        end
        exp_q.delete();
        tp_q.delete();
        st_q.delete();
        fresh = 1'b1;
      end else begin
        stall = out_valid && !out_ready;
        n_cmp++;
        if (in_ready !== !stall) begin
          n_fail++;
          $display("FAIL cfg%0d in_ready: got %0b, want %0b", g, in_ready, !stall);
        end
        if (in_ready === 1'b0) saw_block = 1'b1;
        if (out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cfg%0d spurious_out: got sum=%0h with no op pending, want none", g,
                     out_sum);
          end else begin
            if (fresh) begin
              lat = cyc - tp_q[0];
              n_cmp++;
              if (lat != S + stall_cnt - st_q[0]) begin
                n_fail++;
                $display("FAIL cfg%0d latency: got %0d, want %0d", g, lat,
                         S + stall_cnt - st_q[0]);
              end
            end
            if (out_ready) begin
              e = exp_q.pop_front();
              void'(tp_q.pop_front());
              void'(st_q.pop_front());
              n_cmp++;
              if ({out_cout, out_sum} !== e) begin
                n_fail++;
                $display("FAIL cfg%0d result: got cout=%0b sum=%0h, want cout=%0b sum=%0h", g,
                         out_cout, out_sum, e[W], e[W-1:0]);
              end
            end
          end
          fresh = out_ready;
        end else begin
          n_cmp++;
          if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg%0d idle_out: valid=%0b sum=%0h cout=%0b, want 0/0/0", g,
                     out_valid, out_sum, out_cout);
          end
          fresh = 1'b1;
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(ref_add(in_a, in_b, in_cin));
          tp_q.push_back(cyc);
          st_q.push_back(stall_cnt);
        end
        if (stall) stall_cnt++;
        cyc++;
      end
    end

    initial begin
      forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 9) < 7);
      end
    end

    initial begin
      int k;
      int t;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      out_ready = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      if (g == 0) begin
        // Three ops in flight, then an asynchronous reset discards them.
        for (int i = 0; i < 3; i++) send(rnd(), rnd(), 1'($urandom_range(0, 1)));
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        send(W'(32'h0000_0005), W'(32'h0000_0003), 1'b1);
        repeat (8) @(posedge clk);
        #1;
        send(W'(32'h0000_FFFF), W'(32'h0000_0001), 1'b0);
        repeat (8) @(posedge clk);
        #1;
        send('1, '0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        saw_block = 1'b0;
        fork
          begin
            for (int i = 0; i < 8; i++) send(rnd(), rnd(), 1'($urandom_range(0, 1)));
          end
          begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
          end
        join
        repeat (12) @(posedge clk);
        #1;
        n_cmp++;
        if (!saw_block) begin
          n_fail++;
          $display("FAIL cfg%0d backpressure_block: in_ready never 0, want 0 while full", g);
        end
      end
      rnd_rdy = 1'b1;
      for (int i = 0; i < cfg_ops(g); i++) begin
        k = $urandom_range(0, 2);
        repeat (k) begin
          @(posedge clk);
          #1;
        end
        send(rnd(), rnd(), 1'($urandom_range(0, 1)));
      end
      rnd_rdy = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
        @(posedge clk);
        t++;
      end
      if (exp_q.size() != 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL cfg%0d drain: %0d results outstanding, want 0", g, exp_q.size());
      end
      done = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(blk[0].done && blk[1].done && blk[2].done && blk[3].done) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 60000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: run incomplete after %0d cycles, want all configs done", t);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_unsigned_adder.md
# pipelined_unsigned_adder

Parametrised, pipelined unsigned adder: WIDTH-bit operands plus carry-in produce a WIDTH-bit sum and carry-out. The carry chain is split into STAGES equal slices, with one register stage per slice, so long adds close timing at full clock rate. It sits in the datapath as a streaming arithmetic unit behind a valid/ready handshake, accepting one operation per cycle. It supersedes the fixed 32-bit combinational adder.

## Interface
- WIDTH, 32: operand and sum width in bits; must be ≥ 1.
- STAGES, 4: number of pipeline slices; 1 ≤ STAGES ≤ WIDTH, and WIDTH % STAGES == 0.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set on in_a/in_b/in_cin is valid.
- in_ready  output  1  adder accepts an operand set this cycle.
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- in_cin  input  1  carry-in.
- out_valid  output  1  out_sum/out_cout hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- out_sum  output  WIDTH  sum, modulo 2^WIDTH, or saturated (see Configuration).
- out_cout  output  1  carry-out of the full WIDTH-bit add.

## Operation
- SLICE = WIDTH/STAGES. Stage k adds bits [k·SLICE +: SLICE] of A and B plus the carry registered by stage k−1. Stage 0 uses in_cin.
- Operand skew: upper slices travel in delay registers until their stage. Completed low sum slices travel forward in registers, so all slices emerge aligned.
- Each stage holds a valid bit. A global advance = !out_valid || out_ready. When advance is 1, every stage loads from its predecessor, and stage 0 loads in_valid && in_ready.
- in_ready = advance (combinational from out_valid and out_ready). No skid buffer. Bubbles inside the pipe are not collapsed.
- When advance is 0, all stage registers and valid bits hold. out_sum/out_cout stay stable while out_valid && !out_ready.
- Data registers update only when advance is 1. Their value when the stage valid bit is 0 is don't-care, except out_sum/out_cout, which must be 0 when out_valid is 0.
- Result for a valid input: {out_cout, out_sum} = in_a + in_b + in_cin, with (WIDTH+1)-bit exact arithmetic.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0, out_valid 0, out_sum 0, out_cout 0, in_ready 1. Carry and data registers reset to 0.
- Reset mid-operation: all in-flight operations are discarded. There is no output for them after rst_n rises.
- Latency: exactly STAGES cycles from the accepting edge (in_valid && in_ready) to out_valid high, with no stall.
- Throughput: one operation per cycle while out_ready is held at 1.
- Simultaneous pop and push: when out_valid && out_ready && in_valid, the pipeline shifts, a new operand set enters, and the presented result retires, all on the same edge.
- Full pipeline with out_ready low: in_ready is 0, no input is accepted, and nothing is lost or duplicated.
- STAGES = 1: a single registered add. Latency 1, same handshake.
- Carry wrap-around: all-ones + 1 gives out_sum 0, out_cout 1.

## Configuration
- UADD_SATURATE_EN defined: when the full add carries out, out_sum is forced to all-ones and out_cout still reads 1 (overflow flag). Saturation is applied at the final stage only.
- UADD_SATURATE_EN undefined: out_sum wraps modulo 2^WIDTH and out_cout is the raw carry.

## Structure
- Shared package uadd_pkg holds:
  - default constants UADD_WIDTH_DEF = 32 and UADD_STAGES_DEF = 4;
  - an elaboration-check helper for WIDTH % STAGES.
- An illegal parameter combination triggers $fatal at elaboration.
- One natural sub-module: uadd_slice (combinational SLICE-bit adder, carry-in to sum and carry-out), instantiated STAGES times via generate.
- Skew/deskew registers and the valid/advance control live in the top module.

## Test plan
- Reset and idle: assert rst_n low mid-stream with 3 ops in flight, release it, and hold in_valid 0. Required: out_valid stays 0, out_sum = 0, in_ready = 1, and no stale result appears.
- Basic add: in_a = 0x0000_0005, in_b = 0x0000_0003, in_cin = 1. Required: after exactly 4 cycles, out_sum = 0x0000_0009 and out_cout = 0.
- Cross-slice carry: in_a = 0x0000_FFFF, in_b = 0x0000_0001, in_cin = 0. Required: out_sum = 0x0001_0000.
- Wrap-around: in_a = 0xFFFF_FFFF, in_b = 0x0000_0000, in_cin = 1. Required:
  - without UADD_SATURATE_EN: out_sum = 0x0000_0000, out_cout = 1;
  - with UADD_SATURATE_EN: out_sum = 0xFFFF_FFFF, out_cout = 1.
- Backpressure: stream 8 back-to-back random ops, drop out_ready for 5 cycles, then hold it high. Required: all 8 results arrive in order and match a reference model, with none dropped or duplicated. in_ready goes 0 while the pipe is full and stalled.
- Parameter sweep: (WIDTH, STAGES) = (8,1), (16,2), (64,8). Run 1000 random ops with random in_valid/out_ready. Required: every result equals the (WIDTH+1)-bit reference sum, and latency equals STAGES when unstalled.
